// File: rtl/count_slot_arbiter.sv
// Round-robin sequencer that shares one down-counting interval timer between NREQ requesters.
// Every output is registered. Reset is synchronous and active-low.
module count_slot_arbiter #(
    parameter int NREQ = 4,
    parameter int CW   = 3,
    parameter int IDW  = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NREQ-1:0]    req,
    input  logic [NREQ*CW-1:0] len,
    output logic [NREQ-1:0]    grant,
    output logic               busy,
    output logic [CW-1:0]      cnt,
    output logic               done,
    output logic [IDW-1:0]     done_id,
    output logic               aborted
);

    typedef enum logic [1:0] {IDLE, COUNT, DONE} state_t;

    state_t           state, state_n;
    logic [IDW-1:0]   ptr, ptr_n, owner, owner_n, winner, owner_inc;
    logic [NREQ-1:0]  grant_n;
    logic             busy_n, done_n, aborted_n, found;
    logic [CW-1:0]    cnt_n;
    logic [IDW-1:0]   done_id_n;
    int unsigned      idx;

    // Scan starts at ptr and wraps, so the first active requester at or after ptr wins.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        idx    = 0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            idx = (32'(ptr) + k) % NREQ;
            if (!found && req[idx]) begin
                found  = 1'b1;
                winner = IDW'(idx);
            end
        end
    end

    assign owner_inc = (owner == IDW'(NREQ - 1)) ? '0 : owner + 1'b1;

    always_comb begin
        state_n   = state;
        ptr_n     = ptr;
        owner_n   = owner;
        grant_n   = grant;
        busy_n    = busy;
        cnt_n     = cnt;
        done_n    = done;
        done_id_n = done_id;
        aborted_n = aborted;
        case (state)
            IDLE: begin
                if (found) begin
                    owner_n         = winner;
                    grant_n         = '0;
                    grant_n[winner] = 1'b1;
                    cnt_n           = len[winner*CW +: CW];
                    state_n         = COUNT;
                    busy_n          = 1'b1;
                end
            end
            COUNT: begin
                // An owner dropping its request ends the slot even when cnt has also reached zero.
                if (!req[owner]) begin
                    state_n   = DONE;
                    aborted_n = 1'b1;
                    done_n    = 1'b1;
                    done_id_n = owner;
                end else if (cnt == '0) begin
                    state_n   = DONE;
                    aborted_n = 1'b0;
                    done_n    = 1'b1;
                    done_id_n = owner;
                end else begin
                    cnt_n = cnt - 1'b1;
                end
            end
            DONE: begin
                state_n   = IDLE;
                grant_n   = '0;
                busy_n    = 1'b0;
                done_n    = 1'b0;
                aborted_n = 1'b0;
                ptr_n     = owner_inc;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= IDLE;
            ptr     <= '0;
            owner   <= '0;
            grant   <= '0;
            busy    <= 1'b0;
            cnt     <= '0;
            done    <= 1'b0;
            done_id <= '0;
            aborted <= 1'b0;
        end else begin
            state   <= state_n;
            ptr     <= ptr_n;
            owner   <= owner_n;
            grant   <= grant_n;
            busy    <= busy_n;
            cnt     <= cnt_n;
            done    <= done_n;
            done_id <= done_id_n;
            aborted <= aborted_n;
        end
    end

endmodule

// File: tb/tb_count_slot_arbiter.sv
// Scoreboard bench for count_slot_arbiter: stimulus queues expected grant/done events,
// and a negedge monitor pops and compares them when the DUT presents them.
module tb_count_slot_arbiter;

    logic        clk;
    logic        rst;
    logic [3:0]  req;
    logic [11:0] len;
    logic [3:0]  grant;
    logic        busy;
    logic [2:0]  cnt;
    logic        done;
    logic [1:0]  done_id;
    logic        aborted;

    int checks = 0;
    int errors = 0;

    typedef struct { logic [3:0] g; logic [2:0] c; } gexp_t;
    typedef struct { logic [1:0] id; logic ab; logic [2:0] c; } dexp_t;
    gexp_t gq[$];
    dexp_t dq[$];
    logic  prev_busy = 1'b0;

    count_slot_arbiter #(.NREQ(4), .CW(3), .IDW(2)) dut (
        .clk(clk), .rst(rst), .req(req), .len(len), .grant(grant), .busy(busy),
        .cnt(cnt), .done(done), .done_id(done_id), .aborted(aborted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_g(input logic [3:0] g, input logic [2:0] c);
        gexp_t e;
        e.g = g; e.c = c;
        gq.push_back(e);
    endtask

    task automatic push_d(input logic [1:0] id, input logic ab, input logic [2:0] c);
        dexp_t e;
        e.id = id; e.ab = ab; e.c = c;
        dq.push_back(e);
    endtask

    task automatic chk_idle(input string name);
        chk({name, "_grant"}, 32'(grant), 0);
        chk({name, "_busy"}, 32'(busy), 0);
        chk({name, "_cnt"}, 32'(cnt), 0);
        chk({name, "_done"}, 32'(done), 0);
        chk({name, "_done_id"}, 32'(done_id), 0);
        chk({name, "_aborted"}, 32'(aborted), 0);
    endtask

    // Monitor: a new grant is a rising busy; a completion is done=1.
    always @(negedge clk) begin
        if (rst === 1'b1 && busy === 1'b1 && prev_busy === 1'b0) begin
            if (gq.size() == 0) begin
                checks++; errors++;
                $display("FAIL grant_evt unexpected actual=%0h expected=none", grant);
            end else begin
                gexp_t e;
                e = gq.pop_front();
                chk("grant_evt", 32'(grant), 32'(e.g));
                chk("grant_evt_cnt", 32'(cnt), 32'(e.c));
            end
        end
        if (done === 1'b1) begin
            if (dq.size() == 0) begin
                checks++; errors++;
                $display("FAIL done_evt unexpected actual_id=%0d expected=none", done_id);
            end else begin
                dexp_t e;
                e = dq.pop_front();
                chk("done_evt_id", 32'(done_id), 32'(e.id));
                chk("done_evt_aborted", 32'(aborted), 32'(e.ab));
                chk("done_evt_cnt", 32'(cnt), 32'(e.c));
            end
        end
        prev_busy = busy;
    end

    initial begin
        // Reset with random inputs, then release with no requests.
        rst = 1'b0;
        req = 4'($urandom);
        len = 12'($urandom);
        step();
        step();
        chk_idle("reset");
        rst = 1'b1;
        req = 4'b0000;
        step();
        step();
        chk_idle("post_reset");

        // Single slot, requester 1, length 3.
        req = 4'b0010;
        len = 12'h018;
        push_g(4'b0010, 3'd3);
        push_d(2'd1, 1'b0, 3'd0);
        step();
        chk("single_grant", 32'(grant), 32'h2);
        chk("single_cnt0", 32'(cnt), 3);
        for (int i = 1; i <= 3; i++) begin
            step();
            chk("single_cnt", 32'(cnt), 32'(3 - i));
        end
        step();
        chk("single_done", 32'(done), 1);
        req = 4'b0000;
        step();
        chk("single_release_grant", 32'(grant), 0);
        chk("single_release_busy", 32'(busy), 0);

        // Reset to bring ptr back to 0 before the round-robin run.
        rst = 1'b0;
        step();
        rst = 1'b1;
        step();

        // Round-robin over all four requesters with zero-length slots.
        req = 4'b1111;
        len = 12'h000;
        for (int i = 0; i < 5; i++) begin
            push_g(4'(1 << (i % 4)), 3'd0);
            push_d(2'(i % 4), 1'b0, 3'd0);
        end
        for (int i = 0; i < 5; i++) begin
            step();
            chk("rr_grant", 32'(grant), 32'(1 << (i % 4)));
            step();
            chk("rr_done", 32'(done), 1);
            step();
        end
        req = 4'b0000;
        step();
        step();

        // Abort: requester 0 drops its request when cnt=5.
        req = 4'b0001;
        len = 12'd7;
        push_g(4'b0001, 3'd7);
        push_d(2'd0, 1'b1, 3'd5);
        step();
        step();
        step();
        chk("abort_cnt_before", 32'(cnt), 5);
        req = 4'b0000;
        step();
        chk("abort_aborted", 32'(aborted), 1);
        step();
        chk("abort_grant_drop", 32'(grant), 0);
        chk("abort_cnt_hold", 32'(cnt), 5);

        // Reset in the middle of a slot for requester 2.
        req = 4'b0100;
        len = 12'h180;
        push_g(4'b0100, 3'd6);
        step();
        step();
        step();
        chk("midrst_cnt_before", 32'(cnt), 4);
        rst = 1'b0;
        step();
        chk_idle("midrst");
        rst = 1'b1;
        push_g(4'b0100, 3'd6);
        push_d(2'd2, 1'b1, 3'd6);
        step();
        chk("midrst_regrant", 32'(grant), 32'h4);
        req = 4'b0000;
        step();
        step();

        // Fairness and late len change: 0 then 1 then 0 again.
        req = 4'b0011;
        len = 12'h02A;
        push_g(4'b0001, 3'd2);
        push_d(2'd0, 1'b0, 3'd0);
        push_g(4'b0010, 3'd5);
        push_d(2'd1, 1'b0, 3'd0);
        push_g(4'b0001, 3'd7);
        push_d(2'd0, 1'b1, 3'd7);
        step();
        chk("fair_first", 32'(grant), 32'h1);
        len = 12'h02F;
        step();
        step();
        chk("fair_late_len_cnt", 32'(cnt), 0);
        step();
        chk("fair_done0", 32'(done_id), 0);
        step();
        step();
        chk("fair_second", 32'(grant), 32'h2);
        repeat (5) step();
        chk("fair_second_cnt", 32'(cnt), 0);
        step();
        chk("fair_done1", 32'(done_id), 1);
        step();
        step();
        chk("fair_third", 32'(grant), 32'h1);
        chk("fair_third_cnt", 32'(cnt), 7);
        req = 4'b0000;
        step();
        step();
        repeat (3) step();

        chk("grant_queue_empty", 32'(gq.size()), 0);
        chk("done_queue_empty", 32'(dq.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
